// File: rtl/mask_rg_encoder.sv
// Streaming encoder: 11-bit mantissa keep-mask -> 4-bit precision level rg, with malformed-mask flagging.
// Optional saturating error counter on port err_cnt when MASK_ENC_ERRCNT_EN is defined.
`timescale 1ns/1ps
module mask_rg_encoder #(
    parameter int MASK_W = 11,
    parameter int FIX_W  = 4,
    parameter int LVL_W  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [MASK_W-1:0] s_mask,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [LVL_W-1:0]  m_rg,
    output logic              m_err,
    input  logic              clr_err,
    output logic              err_sticky
`ifdef MASK_ENC_ERRCNT_EN
    ,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    localparam int VAR_W = MASK_W - FIX_W;

    if (LVL_W < $clog2(VAR_W + 1) || CNT_W < 1 || FIX_W < 1) begin : g_bad_cfg
        $error("mask_rg_encoder: LVL_W cannot hold the level range or CNT_W/FIX_W is zero");
    end

    // Returns {err, rg}. A legal variable field has its zeros packed at the LSB end,
    // so its complement must be of the form 0..01..1 (z & (z+1) == 0).
    function automatic logic [LVL_W:0] enc_mask(input logic [MASK_W-1:0] mask);
        logic [VAR_W-1:0] z;
        logic [VAR_W-1:0] z_inc;
        logic [LVL_W-1:0] nz;
        logic             ok;
        z     = ~mask[VAR_W-1:0];
        z_inc = z + VAR_W'(1);
        ok    = (&mask[MASK_W-1:VAR_W]) && ((z & z_inc) == '0);
        nz    = '0;
        for (int i = 0; i < VAR_W; i++) begin
            nz = nz + LVL_W'(z[i]);
        end
        return ok ? {1'b0, nz} : {1'b1, {LVL_W{1'b0}}};
    endfunction

    logic              r_vld_p1;
    logic [MASK_W-1:0] r_mask_p1;
    logic              r_vld_p2;
    logic [LVL_W-1:0]  r_rg_p2;
    logic              r_err_p2;
    logic              r_sticky;
    logic              w_s2_adv;
    logic              w_s1_adv;
    logic [LVL_W:0]    w_enc_p1;
    logic              w_err_load;

    assign w_s2_adv   = ~r_vld_p2 | m_ready;
    assign w_s1_adv   = ~r_vld_p1 | w_s2_adv;
    assign s_ready    = w_s1_adv;
    assign w_enc_p1   = enc_mask(r_mask_p1);
    assign w_err_load = w_s2_adv & r_vld_p1 & w_enc_p1[LVL_W];

    // ---- stage 1: capture incoming mask ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_adv) begin
            r_vld_p1 <= s_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (s_valid && w_s1_adv) begin
            r_mask_p1 <= s_mask;
        end
    end

    // ---- stage 2: encoded result, drives the output port directly ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
            r_rg_p2  <= '0;
            r_err_p2 <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_rg_p2  <= w_enc_p1[LVL_W-1:0];
                r_err_p2 <= w_enc_p1[LVL_W];
            end
        end
    end

    // A malformed load beats a simultaneous clear so no error is ever lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
        end else if (w_err_load) begin
            r_sticky <= 1'b1;
        end else if (clr_err) begin
            r_sticky <= 1'b0;
        end
    end

`ifdef MASK_ENC_ERRCNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clr_err) begin
            r_err_cnt <= w_err_load ? CNT_W'(1) : '0;
        end else if (w_err_load && (r_err_cnt != {CNT_W{1'b1}})) begin
            r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign m_valid    = r_vld_p2;
    assign m_rg       = r_rg_p2;
    assign m_err      = r_err_p2;
    assign err_sticky = r_sticky;

endmodule

// File: tb/tb_mask_rg_encoder.sv
// Bench for mask_rg_encoder: directed scenarios plus randomized traffic against a queue-based reference.
`timescale 1ns/1ps
module tb_mask_rg_encoder;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       err;
        logic [3:0] rg;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [10:0] s_mask;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_rg;
    logic        m_err;
    logic        clr_err;
    logic        err_sticky;
`ifdef MASK_ENC_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt;
`endif

    mask_rg_encoder #(.MASK_W(11), .FIX_W(4), .LVL_W(4), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_mask     (s_mask),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_rg       (m_rg),
        .m_err      (m_err),
        .clr_err    (clr_err),
        .err_sticky (err_sticky)
`ifdef MASK_ENC_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    res_t exp_q[$];
    int   n_acc = 0;
    int   n_pop = 0;
    bit   exp_sticky;
    int   exp_cnt;
    bit   hold_pend;
    res_t held;
    logic [10:0] legal [8];

    // Level = count of cleared variable bits; legal only if those zeros are the lowest bits.
    function automatic res_t model(input logic [10:0] m);
        res_t       r;
        int         zeros;
        logic [6:0] v;
        logic [6:0] therm;
        v     = m[6:0];
        zeros = 0;
        for (int i = 0; i < 7; i++) begin
            if (!v[i]) zeros++;
        end
        therm = 7'h7F << zeros;
        r.err = !((m[10:7] == 4'hF) && (v == therm));
        r.rg  = r.err ? 4'd0 : 4'(zeros);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (hold_pend) begin
            chk("hold_vld", m_valid, 1);
            chk("hold_rg", m_rg, held.rg);
            chk("hold_err", m_err, held.err);
        end
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", m_valid, 0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("rg", m_rg, e.rg);
                chk("err", m_err, e.err);
                if (e.err) begin
                    exp_sticky = 1'b1;
                    if (exp_cnt < CNT_MAX) exp_cnt++;
                end
            end
            n_pop++;
        end
        if (s_valid && s_ready) begin
            exp_q.push_back(model(s_mask));
            n_acc++;
        end
        hold_pend = m_valid && !m_ready;
        held      = {m_err, m_rg};
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 20 && (exp_q.size() != 0 || m_valid); k++) tick();
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_vld", m_valid, 0);
    endtask

    task automatic clear_errors();
        clr_err = 1'b1;
        tick();
        clr_err    = 1'b0;
        exp_sticky = 1'b0;
        exp_cnt    = 0;
    endtask

    initial begin
        int a0;
        int p0;
        legal = '{11'h7FF, 11'h7FE, 11'h7FC, 11'h7F8, 11'h7F0, 11'h7E0, 11'h7C0, 11'h780};
        rst = 1'b1; s_valid = 1'b0; s_mask = '0; m_ready = 1'b1; clr_err = 1'b0;
        exp_sticky = 1'b0; exp_cnt = 0; hold_pend = 1'b0; held = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_rg", m_rg, 0);
        chk("rst_m_err", m_err, 0);
        chk("rst_sticky", err_sticky, 0);
`ifdef MASK_ENC_ERRCNT_EN
        chk("rst_cnt", err_cnt, 0);
`endif
        rst = 1'b0;
        tick();
        chk("s_ready_after_rst", s_ready, 1);

        // T2: all legal masks back to back
        a0 = n_acc; p0 = n_pop;
        s_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s_mask = legal[i];
            tick();
        end
        s_valid = 1'b0;
        tick();
        tick();
        chk("t2_accepts", n_acc - a0, 8);
        chk("t2_pops", n_pop - p0, 8);
        chk("t2_sticky", err_sticky, 0);

        // T3: malformed masks
        s_valid = 1'b1; s_mask = 11'h7A5; tick();
        s_mask = 11'h3FF; tick();
        drain();
        chk("t3_sticky", err_sticky, 1);
`ifdef MASK_ENC_ERRCNT_EN
        chk("t3_cnt", err_cnt, 2);
`endif

        // T1: reset with two words in flight
        m_ready = 1'b0;
        s_valid = 1'b1; s_mask = 11'h7FE; tick();
        s_mask = 11'h7FC; tick();
        s_valid = 1'b0;
        chk("t1_full_sready", s_ready, 0);
        rst = 1'b1;
        #2;
        chk("t1_async_vld", m_valid, 0);
        chk("t1_async_sticky", err_sticky, 0);
        exp_q.delete(); exp_sticky = 1'b0; exp_cnt = 0; hold_pend = 1'b0;
        tick();
        rst = 1'b0; m_ready = 1'b1;
        s_valid = 1'b1; s_mask = 11'h780; tick();
        s_valid = 1'b0;
        chk("t1_lat_edge1", m_valid, 0);
        tick();
        chk("t1_lat_edge2", m_valid, 1);
        chk("t1_rg", m_rg, 7);
        chk("t1_err", m_err, 0);
        drain();

        // T4: backpressure for 5 cycles while streaming
        a0 = n_acc; p0 = n_pop;
        m_ready = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_mask = legal[$urandom_range(0, 7)];
            tick();
        end
        chk("t4_accepts", n_acc - a0, 2);
        chk("t4_sready", s_ready, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_mask = legal[$urandom_range(0, 7)];
            tick();
        end
        drain();
        chk("t4_no_loss", n_pop - p0, n_acc - a0);

        // T5: clear coincides with a malformed load
        clear_errors();
        chk("t5_cleared", err_sticky, 0);
`ifdef MASK_ENC_ERRCNT_EN
        chk("t5_cnt_cleared", err_cnt, 0);
`endif
        s_valid = 1'b1; s_mask = 11'h7A5; tick();
        s_valid = 1'b0; clr_err = 1'b1; tick();
        clr_err = 1'b0;
        chk("t5_sticky", err_sticky, 1);
`ifdef MASK_ENC_ERRCNT_EN
        chk("t5_cnt", err_cnt, 1);
`endif
        drain();

`ifdef MASK_ENC_ERRCNT_EN
        // T6: counter saturation
        clear_errors();
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_mask = 11'($urandom) & 11'h3FF;
            tick();
        end
        drain();
        chk("t6_cnt_sat", err_cnt, 3);
        chk("t6_sticky", err_sticky, 1);
`endif

        // Randomized traffic with random backpressure
        clear_errors();
        a0 = n_acc; p0 = n_pop;
        for (int i = 0; i < 300; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            s_mask  = ($urandom_range(0, 1) == 1) ? legal[$urandom_range(0, 7)] : 11'($urandom);
            tick();
        end
        drain();
        chk("rand_no_loss", n_pop - p0, n_acc - a0);
        chk("rand_sticky", err_sticky, exp_sticky);
`ifdef MASK_ENC_ERRCNT_EN
        chk("rand_cnt", err_cnt, exp_cnt);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
